cache_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction cache (fetch side) and the data cache (load/store side) of the rv32i pipeline.
- Each cache issues one cache-line read or write at a time.
- The arbiter grants one requester, latches its command, runs the memory transaction, and returns a one-cycle response.
- Simultaneous requests are resolved round-robin, so neither fetch nor memory stages can starve.

---
 rtl/cache_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one physical-memory port between
// the instruction cache and the data cache; one line transaction at a time.
`default_nettype none

module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] iline_q, iline_d;
  logic [LINE_WIDTH-1:0] dline_q, dline_d;
  logic                  grant_d_sel;

  logic i_req, d_req;
  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    iline_d     = iline_q;
    dline_d     = dline_q;
    grant_d_sel = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the side that did not win last time gets the port.
          grant_d_sel = d_req && (!i_req || !last_d_q);
          state_d     = grant_d_sel ? SERVE_D : SERVE_I;
          addr_d      = (grant_d_sel ? dcache_address : icache_address) & ADDR_MASK;
          write_d     = grant_d_sel && dcache_write;
          last_d_d    = grant_d_sel;
          if (grant_d_sel && dcache_write) begin
            wdata_d = dcache_wdata;
          end
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          iline_d = pmem_rdata;
          state_d = RESP_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          if (!write_q) begin
            dline_d = pmem_rdata;
          end
          state_d = RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      iline_q  <= '0;
      dline_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iline_q  <= iline_d;
      dline_q  <= dline_d;
    end
  end

  assign pmem_read    = (state_q == SERVE_I) || ((state_q == SERVE_D) && !write_q);
  assign pmem_write   = (state_q == SERVE_D) && write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign icache_resp  = (state_q == RESP_I);
  assign dcache_resp  = (state_q == RESP_D);
  assign icache_rdata = iline_q;
  assign dcache_rdata = dline_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and randomized checks of cache_arbiter against a
// transaction-level model of the arbitration and memory handshake.
`default_nettype none

module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int LB = LW / 8;

  logic          clk, rst;
  logic          icache_read, icache_resp;
  logic [AW-1:0] icache_address;
  logic [LW-1:0] icache_rdata;
  logic          dcache_read, dcache_write, dcache_resp;
  logic [AW-1:0] dcache_address;
  logic [LW-1:0] dcache_wdata, dcache_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction model: phase 0 = no transaction, 1 = command to memory,
  // 2 = response to the requester. side 0 = I, 1 = D.
  int            ph, side, m_last;
  bit            m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_iline, m_dline;
  int            grants[$];

  int req_rate;
  bit auto_mem;
  int wait_cnt[2];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void model_reset();
    ph = 0; side = 0; m_last = 1; m_write = 0;
    m_addr = '0; m_wdata = '0; m_iline = '0; m_dline = '0;
    grants.delete();
  endfunction

  function automatic void model_update();
    logic [AW-1:0] a;
    bit ir, dr;
    if (!rst) begin
      model_reset();
      return;
    end
    if (ph == 0) begin
      ir = icache_read;
      dr = dcache_read | dcache_write;
      if (ir || dr) begin
        side    = (ir && dr) ? (1 - m_last) : (ir ? 0 : 1);
        a       = (side == 1) ? dcache_address : icache_address;
        m_addr  = (a / LB) * LB;
        m_write = (side == 1) && dcache_write;
        if (m_write) m_wdata = dcache_wdata;
        m_last  = side;
        grants.push_back(side);
        ph = 1;
      end
    end else if (ph == 1) begin
      if (pmem_resp) begin
        if (!m_write) begin
          if (side == 0) m_iline = pmem_rdata;
          else           m_dline = pmem_rdata;
        end
        ph = 2;
      end
    end else begin
      ph = 0;
    end
  endfunction

  task automatic compare();
    chk("icache_resp", icache_resp, (ph == 2 && side == 0));
    chk("dcache_resp", dcache_resp, (ph == 2 && side == 1));
    chk("pmem_read", pmem_read, (ph == 1 && !m_write));
    chk("pmem_write", pmem_write, (ph == 1 && m_write));
    chk("icache_rdata", icache_rdata, m_iline);
    chk("dcache_rdata", dcache_rdata, m_dline);
    if (ph == 1) begin
      chk("pmem_address", pmem_address, m_addr);
      if (m_write) chk("pmem_wdata", pmem_wdata, m_wdata);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  // Random requesters and memory; each request is dropped the cycle after its resp.
  task automatic drive();
    if (icache_read) begin
      if (icache_resp) begin
        icache_read = 1'b0;
        wait_cnt[0] = 0;
      end
    end else if ($urandom_range(0, 99) < req_rate) begin
      icache_read    = 1'b1;
      icache_address = $urandom;
    end
    if (dcache_read || dcache_write) begin
      if (dcache_resp) begin
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        wait_cnt[1]  = 0;
      end
    end else if ($urandom_range(0, 99) < req_rate) begin
      case ($urandom_range(0, 2))
        0:       begin dcache_read = 1'b1; dcache_write = 1'b0; end
        1:       begin dcache_read = 1'b0; dcache_write = 1'b1; end
        default: begin dcache_read = 1'b1; dcache_write = 1'b1; end
      endcase
      dcache_address = $urandom;
      dcache_wdata   = rand_line();
    end
    for (int s = 0; s < 2; s++) begin
      if ((s == 0) ? icache_read : (dcache_read | dcache_write)) begin
        wait_cnt[s]++;
        if (wait_cnt[s] > 64) begin
          checks++;
          errors++;
          $display("FAIL starvation: side %0d waited %0d cycles, limit 64", s, wait_cnt[s]);
          wait_cnt[s] = 0;
        end
      end
    end
    if (auto_mem) begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if ($urandom_range(0, 2) == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rand_line();
        end
      end else if ($urandom_range(0, 9) == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
      end
    end
  endtask

  logic [LW-1:0] line_l, line_w, line_r;

  initial begin
    rst = 1'b0;
    icache_read = 0; icache_address = '0;
    dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    req_rate = 0; auto_mem = 0; wait_cnt[0] = 0; wait_cnt[1] = 0;
    line_l = rand_line(); line_w = rand_line(); line_r = rand_line();
    model_reset();
    #3;
    chk("reset_pmem_read", pmem_read, 1'b0);
    chk("reset_pmem_write", pmem_write, 1'b0);
    chk("reset_pmem_address", pmem_address, '0);
    chk("reset_pmem_wdata", pmem_wdata, '0);
    chk("reset_icache_rdata", icache_rdata, '0);
    chk("reset_dcache_rdata", dcache_rdata, '0);
    chk("reset_resp", {icache_resp, dcache_resp}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // Instruction-cache line read, memory answers on the second command cycle.
    icache_read = 1'b1; icache_address = 32'h0000_0064;
    step();
    chk("i_read_cmd", {pmem_read, pmem_write}, 2'b10);
    chk("i_read_addr", pmem_address, 32'h0000_0060);
    step();
    pmem_resp = 1'b1; pmem_rdata = line_l;
    step();
    chk("i_read_resp", {icache_resp, dcache_resp}, 2'b10);
    chk("i_read_line", icache_rdata, line_l);
    icache_read = 1'b0; pmem_resp = 1'b0;
    step();
    chk("i_read_resp_once", icache_resp, 1'b0);

    // Data-cache writeback.
    dcache_write = 1'b1; dcache_address = 32'h8000_0020; dcache_wdata = line_w;
    step();
    chk("d_write_cmd", {pmem_read, pmem_write}, 2'b01);
    chk("d_write_addr", pmem_address, 32'h8000_0020);
    chk("d_write_data", pmem_wdata, line_w);
    pmem_resp = 1'b1; pmem_rdata = line_r;
    step();
    chk("d_write_resp", {icache_resp, dcache_resp}, 2'b01);
    chk("d_write_rdata_kept", dcache_rdata, '0);
    dcache_write = 1'b0; pmem_resp = 1'b0;
    step();

    // Address changes after grant are not observed.
    dcache_read = 1'b1; dcache_address = 32'h0000_1040;
    step();
    dcache_address = 32'h1234_5600;
    step();
    chk("d_addr_held", pmem_address, 32'h0000_1040);
    step();
    chk("d_addr_held2", pmem_address, 32'h0000_1040);
    pmem_resp = 1'b1; pmem_rdata = line_r;
    step();
    chk("d_read_line", dcache_rdata, line_r);
    dcache_read = 1'b0; pmem_resp = 1'b0;
    step();

    // Spurious memory response while idle.
    pmem_resp = 1'b1; pmem_rdata = line_w;
    step();
    chk("spurious_resp", {icache_resp, dcache_resp, pmem_read, pmem_write}, 4'b0000);
    step();
    pmem_resp = 1'b0;
    icache_read = 1'b1; icache_address = 32'h0000_0200;
    step();
    chk("grant_after_spurious", pmem_read, 1'b1);
    pmem_resp = 1'b1; pmem_rdata = line_r;
    step();
    icache_read = 1'b0; pmem_resp = 1'b0;
    step();

    // Reset in the middle of an instruction fetch.
    icache_read = 1'b1; icache_address = 32'h0000_0400;
    step();
    chk("pre_reset_cmd", pmem_read, 1'b1);
    rst = 1'b0;
    #2;
    chk("reset_async_cmd", {pmem_read, pmem_write}, 2'b00);
    chk("reset_async_resp", {icache_resp, dcache_resp}, 2'b00);
    model_reset();
    compare();
    dcache_read = 1'b1; dcache_address = 32'h0000_0800;
    step();
    step();
    rst = 1'b1;

    // Continuous dual requests must alternate starting with I.
    req_rate = 100; auto_mem = 1;
    for (int n = 0; n < 80 && grants.size() < 4; n++) begin
      step();
      drive();
    end
    chk("grant_count_ge4", (grants.size() >= 4), 1'b1);
    if (grants.size() >= 4) begin
      chk("grant_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]}, 4'b0101);
    end

    // Randomized traffic at two load levels, then drain.
    req_rate = 30;
    for (int n = 0; n < 1500; n++) begin step(); drive(); end
    req_rate = 100;
    for (int n = 0; n < 500; n++) begin step(); drive(); end
    req_rate = 0;
    for (int n = 0; n < 150; n++) begin step(); drive(); end
    chk("drained", {icache_read, dcache_read | dcache_write}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
